// File: rtl/buzzer_round_ctrl.sv
// Round controller for the buzzer quiz system.
// It arms a round and picks the first team to buzz, with A > B > C priority on a same-cycle tie.
// Teams that answered wrongly stay locked out for the rest of the round.
// It applies the judge's verdict to saturating 4-bit scores and drives the one-hot team-select
// lines that feed the score-digit decoder.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  arm a new round (honoured only in IDLE)
//   buz_a/buz_b/buz_c      debounced buzzer levels; only rising edges count
//   correct/wrong          judge verdict pulses
//   score_A/B/C            one-hot display select: the rotation in IDLE/ARMED, the winner otherwise
//   SA/SB/SC               team scores
//   winner                 one-hot {A,B,C} of the team holding the floor, 0 if none
//   armed                  high while waiting for a buzz
//   timeout                one-cycle pulse when the answer window expires
module buzzer_round_ctrl #(
  parameter int unsigned ANSWER_TICKS = 1000,
  parameter int unsigned DISP_HOLD    = 500,
  parameter int unsigned SCORE_MAX    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       buz_a,
  input  logic       buz_b,
  input  logic       buz_c,
  input  logic       correct,
  input  logic       wrong,
  output logic       score_A,
  output logic       score_B,
  output logic       score_C,
  output logic [3:0] SA,
  output logic [3:0] SB,
  output logic [3:0] SC,
  output logic [2:0] winner,
  output logic       armed,
  output logic       timeout
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StAnswer = 2'd2;
  localparam logic [1:0] StResult = 2'd3;

  localparam int unsigned TmrMax = (ANSWER_TICKS > DISP_HOLD) ? ANSWER_TICKS : DISP_HOLD;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam int unsigned HoldW  = $clog2(DISP_HOLD + 1);
  localparam logic [3:0]  SMax   = 4'(SCORE_MAX);

  logic [1:0]       state_q, state_d;
  logic [2:0]       winner_q, winner_d;
  logic [2:0]       mask_q, mask_d;
  logic [2:0]       prev_q;
  logic             verdict_q, verdict_d;   // 1: last verdict was correct
  logic             timeout_q, timeout_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;           // answer window, then result hold
  logic [2:0]       rot_q, rot_d;           // one-hot {A,B,C} idle rotation
  logic [HoldW-1:0] rot_cnt_q, rot_cnt_d;
  logic [3:0]       score_q [3];            // index 2=A, 1=B, 0=C, matching winner bits
  logic [3:0]       score_d [3];

  logic [2:0] buz, elig, pick, sel;
  logic       good, bad, expire;

  assign buz  = {buz_a, buz_b, buz_c};
  assign elig = buz & ~prev_q & ~mask_q;
  assign pick = elig[2] ? 3'b100 : (elig[1] ? 3'b010 : 3'b001);

  assign good   = correct & ~wrong;
  assign bad    = wrong & ~correct;
  // Both pulses high count as no verdict, so the window can still expire.
  assign expire = ~good & ~bad & (tmr_q == TmrW'(ANSWER_TICKS - 1));

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    mask_d    = mask_q;
    verdict_d = verdict_q;
    timeout_d = 1'b0;
    tmr_d     = tmr_q;
    rot_d     = rot_q;
    rot_cnt_d = rot_cnt_q;
    score_d   = score_q;

    // Rotation only runs while nobody holds the floor; it stays frozen through ANSWER/RESULT.
    if (state_q == StIdle || state_q == StArmed) begin
      if (rot_cnt_q == HoldW'(DISP_HOLD - 1)) begin
        rot_cnt_d = '0;
        rot_d     = {rot_q[0], rot_q[2:1]};
      end else begin
        rot_cnt_d = rot_cnt_q + HoldW'(1);
      end
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StArmed;
          mask_d  = '0;
        end
      end
      StArmed: begin
        if (elig != 3'b000) begin
          state_d  = StAnswer;
          winner_d = pick;
          tmr_d    = '0;
        end
      end
      StAnswer: begin
        tmr_d = tmr_q + TmrW'(1);
        if (good || bad || expire) begin
          state_d   = StResult;
          tmr_d     = '0;
          verdict_d = good;
          timeout_d = expire;
          if (!good) mask_d = mask_q | winner_q;
          for (int i = 0; i < 3; i++) begin
            if (winner_q[i]) begin
              if (good) begin
                if (score_q[i] < SMax) score_d[i] = score_q[i] + 4'd1;
              end else if (score_q[i] != 4'd0) begin
                score_d[i] = score_q[i] - 4'd1;
              end
            end
          end
        end
      end
      default: begin // StResult
        tmr_d = tmr_q + TmrW'(1);
        if (tmr_q == TmrW'(DISP_HOLD - 1)) begin
          winner_d = '0;
          if (verdict_q || mask_q == 3'b111) begin
            state_d   = StIdle;
            rot_d     = 3'b100;
            rot_cnt_d = '0;
          end else begin
            state_d = StArmed;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      winner_q  <= '0;
      mask_q    <= '0;
      prev_q    <= '0;
      verdict_q <= 1'b0;
      timeout_q <= 1'b0;
      tmr_q     <= '0;
      rot_q     <= 3'b100;
      rot_cnt_q <= '0;
      score_q   <= '{default: 4'd0};
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      mask_q    <= mask_d;
      prev_q    <= buz;
      verdict_q <= verdict_d;
      timeout_q <= timeout_d;
      tmr_q     <= tmr_d;
      rot_q     <= rot_d;
      rot_cnt_q <= rot_cnt_d;
      score_q   <= score_d;
    end
  end

  assign sel = (state_q == StAnswer || state_q == StResult) ? winner_q : rot_q;
  assign {score_A, score_B, score_C} = sel;

  assign SA      = score_q[2];
  assign SB      = score_q[1];
  assign SC      = score_q[0];
  assign winner  = winner_q;
  assign armed   = (state_q == StArmed);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_buzzer_round_ctrl.sv
// Bench for buzzer_round_ctrl: directed rounds.
// A behavioural model counts cycles per phase and team scores as plain integers.
// A negedge compare process checks every output on every cycle outside reset.
// Literal checks pin the model at key points of each scenario.
module tb_buzzer_round_ctrl;

  localparam int AT = 8;
  localparam int DH = 4;
  localparam int SM = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, buz_a = 1'b0, buz_b = 1'b0, buz_c = 1'b0, correct = 1'b0, wrong = 1'b0;
  logic score_A, score_B, score_C, armed, timeout;
  logic [3:0] SA, SB, SC;
  logic [2:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_round_ctrl #(.ANSWER_TICKS(AT), .DISP_HOLD(DH), .SCORE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .start(start), .buz_a(buz_a), .buz_b(buz_b), .buz_c(buz_c),
    .correct(correct), .wrong(wrong), .score_A(score_A), .score_B(score_B),
    .score_C(score_C), .SA(SA), .SB(SB), .SC(SC), .winner(winner), .armed(armed),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 armed, 2 answering, 3 showing result; team index 0=A, 1=B, 2=C
  int m_phase, m_win, m_rot, m_rot_n, m_n;
  int m_score [3];
  bit m_lock [3];
  bit m_prev [3];
  bit m_good, m_tmo;
  bit b [3];
  int first;

  task automatic rotate_step();
    m_rot_n++;
    if (m_rot_n == DH) begin
      m_rot   = (m_rot + 1) % 3;
      m_rot_n = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_win = -1; m_rot = 0; m_rot_n = 0; m_n = 0; m_good = 0; m_tmo = 0;
      for (int i = 0; i < 3; i++) begin
        m_score[i] = 0; m_lock[i] = 0; m_prev[i] = 0;
      end
    end else begin
      b[0] = buz_a; b[1] = buz_b; b[2] = buz_c;
      m_tmo = 0;
      case (m_phase)
        0: begin
          rotate_step();
          if (start) begin
            m_phase = 1;
            for (int i = 0; i < 3; i++) m_lock[i] = 0;
          end
        end
        1: begin
          rotate_step();
          first = -1;
          for (int i = 2; i >= 0; i--) if (b[i] && !m_prev[i] && !m_lock[i]) first = i;
          if (first >= 0) begin
            m_win = first; m_phase = 2; m_n = 0;
          end
        end
        2: begin
          m_n++;
          if (correct && !wrong) begin
            if (m_score[m_win] < SM) m_score[m_win]++;
            m_good = 1; m_phase = 3; m_n = 0;
          end else if ((wrong && !correct) || m_n == AT) begin
            m_tmo = !(wrong && !correct);
            if (m_score[m_win] > 0) m_score[m_win]--;
            m_lock[m_win] = 1;
            m_good = 0; m_phase = 3; m_n = 0;
          end
        end
        default: begin
          m_n++;
          if (m_n == DH) begin
            m_win = -1;
            if (m_good || (m_lock[0] && m_lock[1] && m_lock[2])) begin
              m_phase = 0; m_rot = 0; m_rot_n = 0;
            end else begin
              m_phase = 1;
            end
          end
        end
      endcase
      for (int i = 0; i < 3; i++) m_prev[i] = b[i];
    end
  end

  function automatic int onehot(input int idx);
    if (idx < 0) return 0;
    return 4 >> idx;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("select", {29'd0, score_A, score_B, score_C},
            onehot((m_phase >= 2) ? m_win : m_rot));
      check("SA", {28'd0, SA}, m_score[0]);
      check("SB", {28'd0, SB}, m_score[1]);
      check("SC", {28'd0, SC}, m_score[2]);
      check("winner", {29'd0, winner}, onehot(m_win));
      check("armed", {31'd0, armed}, int'(m_phase == 1));
      check("timeout", {31'd0, timeout}, int'(m_tmo));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_buz(input int team, input logic v);
    case (team)
      0: buz_a = v;
      1: buz_b = v;
      default: buz_c = v;
    endcase
  endtask

  // Full round from IDLE: team wins, verdict given, result shown, back to IDLE.
  task automatic play(input int team, input bit good);
    set_buz(team, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    set_buz(team, 1'b1); cyc();
    if (good) correct = 1'b1; else wrong = 1'b1;
    cyc();
    correct = 1'b0; wrong = 1'b0;
    set_buz(team, 1'b0);
    repeat (DH) cyc();
  endtask

  initial begin
    #12 rst = 1'b0;
    check("reset_selA", {31'd0, score_A}, 1);
    check("reset_winner", {29'd0, winner}, 0);
    check("reset_SB", {28'd0, SB}, 0);

    // 1: rotation and a correct round for B
    repeat (4) cyc(); check("rot_B", {29'd0, score_A, score_B, score_C}, 3'b010);
    repeat (4) cyc(); check("rot_C", {29'd0, score_A, score_B, score_C}, 3'b001);
    repeat (4) cyc(); check("rot_A", {29'd0, score_A, score_B, score_C}, 3'b100);
    start = 1'b1; cyc(); start = 1'b0;
    check("armed_after_start", {31'd0, armed}, 1);
    buz_b = 1'b1; cyc();
    check("t1_winner", {29'd0, winner}, 3'b010);
    check("t1_selB", {31'd0, score_B}, 1);
    correct = 1'b1; cyc(); correct = 1'b0;
    check("t1_SB", {28'd0, SB}, 1);
    repeat (3) cyc(); check("t1_result_hold", {29'd0, winner}, 3'b010);
    cyc();
    check("t1_idle_selA", {31'd0, score_A}, 1);
    check("t1_idle_winner", {29'd0, winner}, 0);
    buz_b = 1'b0; cyc();

    // 3: lockouts until every team has failed
    start = 1'b1; cyc(); start = 1'b0;
    buz_a = 1'b1; cyc(); check("t3_winA", {29'd0, winner}, 3'b100);
    wrong = 1'b1; cyc(); wrong = 1'b0;
    check("t3_SA_floor", {28'd0, SA}, 0);
    repeat (DH) cyc(); check("t3_rearmed", {31'd0, armed}, 1);
    buz_a = 1'b0; cyc(); buz_a = 1'b1; cyc();
    check("t3_A_locked", {29'd0, winner}, 0);
    buz_c = 1'b1; cyc(); check("t3_winC", {29'd0, winner}, 3'b001);
    wrong = 1'b1; cyc(); wrong = 1'b0;
    repeat (DH) cyc();
    buz_b = 1'b1; cyc(); check("t3_winB", {29'd0, winner}, 3'b010);
    wrong = 1'b1; cyc(); wrong = 1'b0;
    check("t3_SB_dec", {28'd0, SB}, 0);
    repeat (DH) cyc();
    check("t3_all_locked_idle", {31'd0, armed}, 0);
    buz_a = 1'b0; buz_b = 1'b0; buz_c = 1'b0; cyc();

    // 2: same-cycle tie, then a buzzer held across arming
    start = 1'b1; cyc(); start = 1'b0;
    buz_a = 1'b1; buz_c = 1'b1; cyc(); check("t2_tie_A", {29'd0, winner}, 3'b100);
    correct = 1'b1; cyc(); correct = 1'b0;
    check("t2_SA", {28'd0, SA}, 1);
    repeat (DH) cyc();
    buz_c = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc(); check("t2_held_no_win", {29'd0, winner}, 0);
    buz_a = 1'b0; cyc(); buz_a = 1'b1; cyc();
    check("t2_repress_win", {29'd0, winner}, 3'b100);

    // 4: no verdict, answer window expires
    repeat (AT - 1) cyc(); check("t4_no_timeout_yet", {31'd0, timeout}, 0);
    cyc();
    check("t4_timeout", {31'd0, timeout}, 1);
    check("t4_SA_dec", {28'd0, SA}, 0);
    cyc(); check("t4_timeout_pulse", {31'd0, timeout}, 0);
    repeat (DH - 1) cyc(); check("t4_rearmed", {31'd0, armed}, 1);
    buz_b = 1'b1; cyc(); buz_b = 1'b0;
    check("t4_winB", {29'd0, winner}, 3'b010);
    correct = 1'b1; cyc(); correct = 1'b0;
    repeat (DH) cyc();

    // 5: saturation and simultaneous verdicts
    for (int r = 0; r < 15; r++) play(0, 1'b1);
    check("t5_SA15", {28'd0, SA}, 15);
    play(0, 1'b1);
    check("t5_SA_sat", {28'd0, SA}, 15);
    start = 1'b1; cyc(); start = 1'b0;
    buz_a = 1'b1; cyc();
    correct = 1'b1; wrong = 1'b1; repeat (3) cyc();
    check("t5_both_ignored", {29'd0, winner}, 3'b100);
    wrong = 1'b0; cyc(); correct = 1'b0;
    check("t5_SA_after", {28'd0, SA}, 15);
    buz_a = 1'b0;
    repeat (DH) cyc();

    // 6: reset in the middle of an answer
    for (int r = 0; r < 4; r++) play(1, 1'b1);
    check("t6_SB5", {28'd0, SB}, 5);
    start = 1'b1; cyc(); start = 1'b0;
    buz_b = 1'b1; cyc();
    check("t6_winB", {29'd0, winner}, 3'b010);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_SB", {28'd0, SB}, 0);
    check("t6_rst_winner", {29'd0, winner}, 0);
    check("t6_rst_selA", {29'd0, score_A, score_B, score_C}, 3'b100);
    check("t6_rst_armed", {31'd0, armed}, 0);
    #10 rst = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
